debounce_edge_detect: RTL and testbench

//  Conditions one asynchronous, bouncy input (button/switch/external strobe) for the core logic.

---
 rtl/debounce_edge_detect_pkg.sv | 20 ++
 rtl/debounce_edge_detect_if.sv | 19 +
 rtl/debounce_edge_detect_sync_chain.sv | 18 +
 rtl/debounce_edge_detect.sv | 89 ++++++++
 tb/tb_debounce_edge_detect.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the debounce/edge-detect block: filter state encoding and helpers.
package debounce_edge_detect_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

    // Clean level implied by a filter state: a pending change still reports the old level.
    function automatic logic level_of(input db_state_e s);
        return (s == HIGH) || (s == WAIT_LO);
    endfunction

    function automatic logic is_waiting(input db_state_e s);
        return (s == WAIT_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Raw input, sample strobe and conditioned outputs of one debounced line.
interface debounce_edge_detect_if;
    logic din;
    logic sample_en;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din, sample_en,
        input  q, rise, fall, busy
    );

    modport slave (
        input  din, sample_en,
        output q, rise, fall, busy
    );
endinterface

// File: rtl/debounce_edge_detect_sync_chain.sv
// Generic multi-flop synchroniser for a single asynchronous bit; shared by other CDC inputs.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronises and debounces one bouncy asynchronous input, producing a clean level
// plus registered one-cycle rise/fall pulses.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    debounce_edge_detect_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_edge_detect: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_edge_detect: STABLE_CYCLES must be >= 1");
    end

    logic             sync;
    db_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             q_r, rise_r, fall_r, busy_r;
    logic             lvl_cur, lvl_nx;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.din),
        .q     (sync)
    );

    assign lvl_cur = level_of(state);
    assign lvl_nx  = level_of(state_nx);

    // A mismatching sample either advances the count or, on the last one, commits the level;
    // a matching sample abandons any pending change.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.sample_en) begin
            if (sync != lvl_cur) begin
                if (cnt == CNT_LAST) begin
                    state_nx = sync ? HIGH : LOW;
                    cnt_nx   = '0;
                end else begin
                    state_nx = sync ? WAIT_HI : WAIT_LO;
                    cnt_nx   = cnt + CNT_W'(1);
                end
            end else begin
                state_nx = sync ? HIGH : LOW;
                cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are registered from the next state so they line up with state/cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            q_r    <= lvl_nx;
            rise_r <= lvl_nx & ~lvl_cur;
            fall_r <= ~lvl_nx & lvl_cur;
            busy_r <= is_waiting(state_nx);
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.busy = busy_r;
endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: STABLE_CYCLES=4 instance on the main stimulus, plus a
// STABLE_CYCLES=1 instance sharing din with sample_en tied high.
module tb_debounce_edge_detect;

    logic clk;
    logic reset;

    debounce_edge_detect_if b0 ();
    debounce_edge_detect_if b1 ();

    assign b1.din       = b0.din;
    assign b1.sample_en = 1'b1;

    debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // e0 = {q, rise, fall, busy} of dut0; e1 = {q, rise, fall} of dut1, after the edge.
    typedef struct {
        logic       din;
        logic       en;
        logic [3:0] e0;
        logic [2:0] e1;
    } vec_t;

    typedef struct {
        logic [3:0] e0;
        logic [2:0] e1;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int b_rel, b_fall, b_glitch, b_half, b_fall2, b_part;

    function automatic void row(input logic d, input logic en, input logic [3:0] e0,
                                input logic [2:0] e1);
        vec_t v;
        v.din = d; v.en = en; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one record, compares after the following posedge,
    // and returns at the next negedge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        b0.din       = v.din;
        b0.sample_en = v.en;
        e.e0 = v.e0; e.e1 = v.e1; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_dut0"}, {4'd0, b0.q, b0.rise, b0.fall, b0.busy}, {4'd0, e.e0});
            chk({e.tag, "_dut1"}, {5'd0, b1.q, b1.rise, b1.fall}, {5'd0, e.e1});
        end
        @(negedge clk);
    endtask

    task automatic run_rows(input int first, input int n, input string name);
        for (int i = 0; i < n; i++)
            step(tbl[first + i], $sformatf("%s[edge%0d]", name, i + 1));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {1'b0, b0.q, b0.rise, b0.fall, b0.busy, b1.q, b1.rise, b1.fall}, 8'd0);
    endtask

    initial begin
        // release with din=1: dut0 q at edge 6, dut1 at edge 3
        b_rel = tbl.size();
        row(1,1,4'b0000,3'b000); row(1,1,4'b0000,3'b000); row(1,1,4'b0001,3'b110);
        row(1,1,4'b0001,3'b100); row(1,1,4'b0001,3'b100); row(1,1,4'b1100,3'b100);
        row(1,1,4'b1000,3'b100); row(1,1,4'b1000,3'b100);
        // clean fall from q=1
        b_fall = tbl.size();
        row(0,1,4'b1000,3'b100); row(0,1,4'b1000,3'b100); row(0,1,4'b1001,3'b001);
        row(0,1,4'b1001,3'b000); row(0,1,4'b1001,3'b000); row(0,1,4'b0010,3'b000);
        row(0,1,4'b0000,3'b000); row(0,1,4'b0000,3'b000);
        // 3-cycle glitch: too short for dut0, passes through dut1
        b_glitch = tbl.size();
        row(1,1,4'b0000,3'b000); row(1,1,4'b0000,3'b000); row(1,1,4'b0001,3'b110);
        row(0,1,4'b0001,3'b100); row(0,1,4'b0001,3'b100); row(0,1,4'b0000,3'b001);
        row(0,1,4'b0000,3'b000); row(0,1,4'b0000,3'b000);
        // sample_en every other cycle: 4th enabled sample with sync=1 is edge 9
        b_half = tbl.size();
        row(1,1,4'b0000,3'b000); row(1,0,4'b0000,3'b000); row(1,1,4'b0001,3'b110);
        row(1,0,4'b0001,3'b100); row(1,1,4'b0001,3'b100); row(1,0,4'b0001,3'b100);
        row(1,1,4'b0001,3'b100); row(1,0,4'b0001,3'b100); row(1,1,4'b1100,3'b100);
        row(1,0,4'b1000,3'b100);
        b_fall2 = tbl.size();
        row(0,1,4'b1000,3'b100); row(0,1,4'b1000,3'b100); row(0,1,4'b1001,3'b001);
        row(0,1,4'b1001,3'b000); row(0,1,4'b1001,3'b000); row(0,1,4'b0010,3'b000);
        row(0,1,4'b0000,3'b000); row(0,1,4'b0000,3'b000);
        // partial qualification up to cnt=2 in WAIT_HI
        b_part = tbl.size();
        row(1,1,4'b0000,3'b000); row(1,1,4'b0000,3'b000); row(1,1,4'b0001,3'b110);
        row(1,1,4'b0001,3'b100);

        reset        = 1'b0;
        b0.din       = 1'b1;
        b0.sample_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all_zero("reset_hold");
        end
        @(negedge clk);
        reset = 1'b1;
        run_rows(b_rel,    8,  "release");
        run_rows(b_fall,   8,  "fall");
        run_rows(b_glitch, 8,  "glitch");
        run_rows(b_half,   10, "half_rate");
        run_rows(b_fall2,  8,  "fall2");
        run_rows(b_part,   4,  "partial");

        // reset in WAIT_HI: outputs clear without a clock, no pulse follows
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_all_zero("reset_mid_qual");
        end
        @(negedge clk);
        reset = 1'b1;
        run_rows(b_rel, 8, "requal");

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
